// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchronizers, clock de-glitch filter, 11-bit frame
// deserializer with odd parity, E0/F0 prefix folding and a small FWFT event FIFO.
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       PS2_clk,
  input  logic       PS2_Data,
  input  logic       rd_en,
  output logic [9:0] dout,
  output logic       empty,
  output logic       overflow,
  output logic       frame_err,
  output logic       busy
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t         state_q, state_d;
  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           good_q, good_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic           frame_err_q, frame_err_d;
  logic           ovf_q, ovf_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           strobe;
  logic           err;
  logic           push;
  logic           pop;
  logic           full;
  logic           wr;
  logic [9:0]     push_data;
  logic [9:0]     mem [FIFO_DEPTH];

  always_comb begin
    clk_s1_d    = PS2_clk;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = PS2_Data;
    dat_s2_d    = dat_s1_q;
    filt_d      = filt_q;
    filt_cnt_d  = filt_cnt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    good_d      = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    strobe      = 1'b0;
    err         = 1'b0;
    push        = 1'b0;
    push_data   = {ext_q, brk_q, shift_q};

    // Filter: the level flips only after FILTER_LEN consecutive differing samples.
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
      filt_d     = clk_s2_q;
      filt_cnt_d = '0;
      strobe     = filt_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    tmo_cnt_d = (state_q == IDLE || strobe) ? '0 : tmo_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (strobe && !dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (strobe) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          if (dat_s2_q && (^shift_q ^ par_q)) good_d = 1'b1;
          else                                 err    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !strobe && tmo_cnt_q == TCW'(TIMEOUT)) begin
      state_d   = IDLE;
      tmo_cnt_d = '0;
      err       = 1'b1;
    end

    // Decode runs one cycle after STOP; shift_q is still stable then.
    if (good_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
    frame_err_d = err;

    pop  = rd_en && (cnt_q != '0);
    full = (cnt_q == CW'(FIFO_DEPTH));
    wr   = push && (!full || pop);
    if (push && full && !pop) ovf_d = 1'b1;
    if (wr)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      good_q      <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      good_q      <= good_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage carries no reset; entries are only visible through the counted window.
  always_ff @(posedge clk_50mhz) begin
    if (wr) mem[wr_ptr_q] <= push_data;
  end

  assign empty     = (cnt_q == '0);
  assign dout      = empty ? 10'd0 : mem[rd_ptr_q];
  assign overflow  = ovf_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver feeding the Top keyboard/display datapath from the board pins PS2_clk and PS2_Data. It synchronizes and de-glitches the device clock and deserializes 11-bit frames with an odd-parity check. It folds E0 (extended) and F0 (break) prefixes into tagged key events and buffers them in a small first-word-fall-through FIFO read by the consumer logic.

Parameters:
FILTER_LEN, 8, consecutive identical clk_50mhz samples required before the filtered PS2 clock changes level
TIMEOUT, 100000, clk_50mhz cycles without a PS2 clock falling edge that abort a partial frame (2 ms)
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2

Ports:
clk_50mhz  input  1  system clock, 50 MHz
rst  input  1  reset, asynchronous, active-high
PS2_clk  input  1  raw PS/2 clock pin, asynchronous
PS2_Data  input  1  raw PS/2 data pin, asynchronous
rd_en  input  1  pop the FIFO head; ignored when empty
dout  output  10  head event {ext, brk, code[7:0]}; 0 when empty
empty  output  1  FIFO empty
overflow  output  1  sticky: an event was dropped because the FIFO was full
frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error
busy  output  1  frame in progress (FSM not IDLE)

Behaviour:
- Reset (async, rst=1): FSM IDLE, bit count 0, shift register 0, ext/brk flags 0, FIFO pointers 0, empty=1, dout=0, overflow=0, frame_err=0, busy=0. Synchronizers and filter preset to 1 (idle bus). Reset mid-frame discards the partial frame.
- Synchronization: 2-flop synchronizer on each pin.
- Filter: the filtered clock takes the new level only after FILTER_LEN consecutive equal synchronized samples. A 1->0 transition of the filtered clock produces a one-cycle sample strobe. Synchronized data is sampled in that same cycle.
- Edge latency: the strobe follows a clean pin edge by 2+FILTER_LEN cycles (±1).
- FSM on each strobe:
  - IDLE: data=0 -> DATA, bit count=0. data=1 -> stay IDLE; no error.
  - DATA: shift data in LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: if data=1 and XOR(8 data bits, parity)=1, the frame is good; otherwise pulse frame_err. Either way -> IDLE.
- Timeout: the cycle counter clears on every strobe and in IDLE. In any non-IDLE state, reaching TIMEOUT forces IDLE and pulses frame_err.
- Error handling: any frame error also clears the ext/brk flags.
- Decode of a good frame:
  - 0xE0 sets ext; nothing is pushed.
  - 0xF0 sets brk; nothing is pushed.
  - Any other code pushes {ext, brk, code} and then clears both flags.
- Push timing: the push occurs in the cycle after the STOP strobe, so empty falls 2 cycles after the STOP strobe.
- FIFO:
  - FWFT: dout = head entry combinationally while !empty.
  - rd_en while !empty advances the read pointer.
  - Push while full with no pop: the event is dropped and overflow sets. overflow clears only on rst.
  - Simultaneous push and pop while full: both are performed, no drop, count unchanged.
  - Simultaneous push and pop while empty: the pop is ignored and the push is performed.
  - Pointers wrap modulo FIFO_DEPTH. A count register of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- frame_err and the push are never caused by the same frame.

Test Plan:
- Send frame 0x1C, LSB-first, parity 0, stop 1, at 10 kHz PS2_clk -> empty 1->0, dout=0x01C, frame_err stays 0. Pulse rd_en -> empty=1, dout=0.
- Send E0, F0, 75 -> exactly one entry, dout=0x375. Then send 1C -> second entry 0x01C (flags cleared).
- Send 0x1C with parity bit 1 -> one frame_err pulse, empty stays 1. Repeat with stop bit 0 -> frame_err, no push.
- Send start bit + 3 data bits, then hold PS2_clk high -> frame_err pulse TIMEOUT cycles after the last strobe, busy=0. A following good 0x1C frame is received correctly.
- With FIFO_DEPTH=4, send 1C,32,21,23,24 with no reads -> overflow=1. Reads return 0x01C,0x032,0x021,0x023, then empty=1. Fill 4 again and assert rd_en in the push cycle of a 5th frame -> no new drop, count stays 4.
- Inject 3-cycle low glitches on PS2_clk mid-frame with FILTER_LEN=8 -> no extra bits sampled, frame decodes correctly. Assert rst mid-frame -> all outputs at reset values, the next frame decodes cleanly.
